// File: rtl/cascade_counter_pkg.sv
// Shared definitions for the cascade_counter block.
//   DIR_UP / DIR_DOWN : encodings of the dir input
//   slice_lo()        : low bit index of stage k inside a packed per-stage bus
package cascade_counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/cascade_counter_stage.sv
// One digit of the cascade: a WIDTH-bit modulo counter with a run-time maximum.
//   clk, rst       : clock, synchronous active-high reset
//   step           : advance this digit on this edge (already gated by lower digits)
//   dir            : DIR_UP / DIR_DOWN
//   max            : largest value this digit holds
//   load           : parallel load strobe, wins over step
//   load_value     : data for load, saturated to max
//   value          : registered digit value
//   wrap           : registered one-cycle wrap/borrow pulse
//   will_wrap      : combinational, this digit wraps on the coming edge (ripple to next digit)
module counter_stage
  import cascade_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             dir,
  input  logic [WIDTH-1:0] max,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             wrap,
  output logic             will_wrap
);

  logic [WIDTH-1:0] value_nxt;

  // A digit sitting above a freshly shrunk max counts as "at the top" going up,
  // but going down it is simply clamped to max without a borrow.
  assign will_wrap = step && ((dir == DIR_UP) ? (value >= max) : (value == '0));

  always_comb begin
    value_nxt = value;
    if (dir == DIR_UP) begin
      value_nxt = (value >= max) ? '0 : value + 1'b1;
    end else begin
      if (value == '0)     value_nxt = max;
      else if (value > max) value_nxt = max;
      else                  value_nxt = value - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      value <= (load_value > max) ? max : load_value;
      wrap  <= 1'b0;
    end else if (step) begin
      value <= value_nxt;
      wrap  <= will_wrap;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: rtl/cascade_counter.sv
// Chain of NUM_STAGES modulo digits; a step on digit 0 ripples carries/borrows
// upward within the same clock edge.
//   clk, rst    : clock, synchronous active-high reset
//   inc         : step digit 0 on this edge
//   dir         : 0 = up, 1 = down
//   max         : per-digit maximum, digit k at [k*WIDTH +: WIDTH]
//   load        : parallel load strobe (priority over inc)
//   load_value  : per-digit load data, same packing as max
//   value       : registered digit values, same packing
//   wrap        : registered per-digit wrap/borrow pulses
//   carry_out   : wrap of the most significant digit
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_STAGES = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inc,
  input  logic                          dir,
  input  logic [NUM_STAGES*WIDTH-1:0]   max,
  input  logic                          load,
  input  logic [NUM_STAGES*WIDTH-1:0]   load_value,
  output logic [NUM_STAGES*WIDTH-1:0]   value,
  output logic [NUM_STAGES-1:0]         wrap,
  output logic                          carry_out
);

  // step[k] enables digit k; step[NUM_STAGES] is the unused ripple past the top.
  logic [NUM_STAGES:0] step;

  assign step[0] = inc;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO = slice_lo(k, WIDTH);

    counter_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .step       (step[k]),
      .dir        (dir),
      .max        (max[LO +: WIDTH]),
      .load       (load),
      .load_value (load_value[LO +: WIDTH]),
      .value      (value[LO +: WIDTH]),
      .wrap       (wrap[k]),
      .will_wrap  (step[k+1])
    );
  end

  // wrap is already registered, so this is a registered output too.
  assign carry_out = wrap[NUM_STAGES-1];

endmodule

// File: tb/tb_cascade_counter.sv
module tb_cascade_counter;

  localparam int W = 4;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           inc;
  logic           dir;
  logic [N*W-1:0] max;
  logic           load;
  logic [N*W-1:0] load_value;
  logic [N*W-1:0] value;
  logic [N-1:0]   wrap;
  logic           carry_out;

  int n_cmp = 0;
  int n_bad = 0;

  cascade_counter #(.WIDTH(W), .NUM_STAGES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .inc        (inc),
    .dir        (dir),
    .max        (max),
    .load       (load),
    .load_value (load_value),
    .value      (value),
    .wrap       (wrap),
    .carry_out  (carry_out)
  );

  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N*W-1:0] exp_v,
                       input logic [N-1:0] exp_w, input logic exp_c);
    n_cmp++;
    assert (value === exp_v) else begin
      n_bad++;
      $error("FAIL %s value: got %h expected %h", tag, value, exp_v);
    end
    n_cmp++;
    assert (wrap === exp_w) else begin
      n_bad++;
      $error("FAIL %s wrap: got %b expected %b", tag, wrap, exp_w);
    end
    n_cmp++;
    assert (carry_out === exp_c) else begin
      n_bad++;
      $error("FAIL %s carry_out: got %b expected %b", tag, carry_out, exp_c);
    end
  endtask

  initial begin
    rst = 1'b1; inc = 1'b1; dir = 1'b0; load = 1'b0;
    max = 12'h959; load_value = '0;

    // reset dominates inc
    edge1(); edge1();
    check("reset", 12'h000, 3'b000, 1'b0);
    rst = 1'b0; inc = 1'b1;
    edge1(); inc = 1'b0;
    check("first_inc", 12'h001, 3'b000, 1'b0);

    // full up ripple
    load = 1'b1; load_value = 12'h959;
    edge1(); load = 1'b0;
    check("load_959", 12'h959, 3'b000, 1'b0);
    inc = 1'b1; dir = 1'b0;
    edge1(); inc = 1'b0;
    check("up_ripple", 12'h000, 3'b111, 1'b1);
    edge1();
    check("up_pulse_end", 12'h000, 3'b000, 1'b0);
    inc = 1'b1;
    edge1(); inc = 1'b0;
    check("up_after", 12'h001, 3'b000, 1'b0);

    // down borrow
    load = 1'b1; load_value = 12'h000;
    edge1(); load = 1'b0;
    inc = 1'b1; dir = 1'b1;
    edge1();
    check("down_borrow", 12'h959, 3'b111, 1'b1);
    edge1(); inc = 1'b0;
    check("down_after", 12'h958, 3'b000, 1'b0);

    // load wins over inc, saturation to max
    load = 1'b1; inc = 1'b1; dir = 1'b0; load_value = 12'h345;
    edge1();
    check("load_wins", 12'h345, 3'b000, 1'b0);
    load_value = 12'h3F5;
    edge1(); load = 1'b0; inc = 1'b0;
    check("load_sat", 12'h355, 3'b000, 1'b0);

    // reset pulse not covering an edge has no effect
    load = 1'b1; load_value = 12'h234;
    edge1(); load = 1'b0;
    @(negedge clk); rst = 1'b1; #2 rst = 1'b0;
    edge1();
    check("rst_glitch", 12'h234, 3'b000, 1'b0);
    rst = 1'b1; inc = 1'b1;
    edge1(); rst = 1'b0; inc = 1'b0;
    check("rst_mid", 12'h000, 3'b000, 1'b0);

    // shrinking max on stage 0
    load = 1'b1; load_value = 12'h007;
    edge1(); load = 1'b0;
    max = 12'h954; inc = 1'b1; dir = 1'b0;
    edge1(); inc = 1'b0;
    check("shrink_max", 12'h010, 3'b001, 1'b0);

    // max1=0 turns stage 1 into a pass-through
    max = 12'h909; load = 1'b1; load_value = 12'h009;
    edge1(); load = 1'b0;
    inc = 1'b1;
    edge1(); inc = 1'b0;
    check("passthru", 12'h100, 3'b011, 1'b0);

    // down with stage 2 above its new max: clamp without borrow
    max = 12'h009; inc = 1'b1; dir = 1'b1;
    edge1(); inc = 1'b0;
    check("down_clamp", 12'h009, 3'b011, 1'b0);

    // all-ones max gives a natural 2^WIDTH modulus
    max = 12'hFFF; load = 1'b1; load_value = 12'hFFF;
    edge1(); load = 1'b0;
    inc = 1'b1; dir = 1'b0;
    edge1(); inc = 1'b0;
    check("full_mod", 12'h000, 3'b111, 1'b1);
    inc = 1'b1; dir = 1'b1;
    edge1(); inc = 1'b0;
    check("full_mod_down", 12'hFFF, 3'b111, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
